scale_coord_gen: RTL

- Downstream consumer of the key-driven scale configuration: x_scale, y_scale, TARGET_H_NUM and TARGET_V_NUM.
- For each output frame, walks the destination raster in row-major order and emits the matching source coordinate (integer part plus fraction) to the scaler's line-buffer read and interpolation stage.
- Scale settings are shadowed at frame start, so key presses never tear a frame.
- Output is a valid/ready stream.

---
 rtl/scale_coord_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/scale_coord_gen.sv
// Walks the destination raster per frame and emits clamped Q.10 source coordinates as a valid/ready stream.
// frame_start -> first beat valid two edges later; outputs hold while stalled; frame_start in RUN/DONE restarts the frame.
module scale_coord_gen #(
    parameter int SRC_H_NUM   = 1280,
    parameter int SRC_V_NUM   = 720,
    parameter int SCALE_WIDTH = 15,
    parameter int FRAC_BITS   = 10,
    parameter int COORD_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   frame_start,
    input  logic [SCALE_WIDTH-1:0] x_scale,
    input  logic [SCALE_WIDTH-1:0] y_scale,
    input  logic [COORD_WIDTH-1:0] TARGET_H_NUM,
    input  logic [COORD_WIDTH-1:0] TARGET_V_NUM,
    output logic                   coord_valid,
    input  logic                   coord_ready,
    output logic [COORD_WIDTH-1:0] src_x,
    output logic [FRAC_BITS-1:0]   src_x_frac,
    output logic [COORD_WIDTH-1:0] src_y,
    output logic [FRAC_BITS-1:0]   src_y_frac,
    output logic [COORD_WIDTH-1:0] dst_x,
    output logic [COORD_WIDTH-1:0] dst_y,
    output logic                   line_last,
    output logic                   frame_last,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int ACC_W = COORD_WIDTH + SCALE_WIDTH + 1;
    localparam int INT_W = ACC_W - FRAC_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LATCH = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COORD_WIDTH-1:0] ONE    = COORD_WIDTH'(1);
    localparam logic [INT_W-1:0]       X_LIM  = INT_W'(SRC_H_NUM - 1);
    localparam logic [INT_W-1:0]       Y_LIM  = INT_W'(SRC_V_NUM - 1);
    localparam logic [COORD_WIDTH-1:0] X_MAXC = COORD_WIDTH'(SRC_H_NUM - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAXC = COORD_WIDTH'(SRC_V_NUM - 1);

    logic [1:0]             r_state;
    logic [SCALE_WIDTH-1:0] r_xs;
    logic [SCALE_WIDTH-1:0] r_ys;
    logic [COORD_WIDTH-1:0] r_h;
    logic [COORD_WIDTH-1:0] r_v;
    logic [ACC_W-1:0]       r_x_acc;
    logic [ACC_W-1:0]       r_y_acc;
    logic [COORD_WIDTH-1:0] r_dst_x;
    logic [COORD_WIDTH-1:0] r_dst_y;
    logic                   r_valid;

    logic             w_xfer;
    logic             w_line_end;
    logic             w_frame_end;
    logic [INT_W-1:0] w_x_int;
    logic [INT_W-1:0] w_y_int;
    logic             w_x_clamp;
    logic             w_y_clamp;

    assign w_xfer      = r_valid && coord_ready;
    assign w_line_end  = (r_dst_x == r_h - ONE);
    assign w_frame_end = w_line_end && (r_dst_y == r_v - ONE);

    assign w_x_int   = r_x_acc[ACC_W-1:FRAC_BITS];
    assign w_y_int   = r_y_acc[ACC_W-1:FRAC_BITS];
    assign w_x_clamp = (w_x_int > X_LIM);
    assign w_y_clamp = (w_y_int > Y_LIM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_xs    <= '0;
            r_ys    <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_x_acc <= '0;
            r_y_acc <= '0;
            r_dst_x <= '0;
            r_dst_y <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start) r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_xs    <= x_scale;
                    r_ys    <= y_scale;
                    r_h     <= TARGET_H_NUM;
                    r_v     <= TARGET_V_NUM;
                    r_x_acc <= '0;
                    r_y_acc <= '0;
                    r_dst_x <= '0;
                    r_dst_y <= '0;
                    if (TARGET_H_NUM != '0 && TARGET_V_NUM != '0) begin
                        r_state <= S_RUN;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_RUN: begin
                    // A resync beats everything, including a coincident final transfer.
                    if (frame_start) begin
                        r_state <= S_LATCH;
                        r_valid <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_frame_end) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                        end else if (w_line_end) begin
                            r_dst_x <= '0;
                            r_x_acc <= '0;
                            r_dst_y <= r_dst_y + ONE;
                            r_y_acc <= r_y_acc + {{(ACC_W-SCALE_WIDTH){1'b0}}, r_ys};
                        end else begin
                            r_dst_x <= r_dst_x + ONE;
                            r_x_acc <= r_x_acc + {{(ACC_W-SCALE_WIDTH){1'b0}}, r_xs};
                        end
                    end
                end
                S_DONE: begin
                    r_state <= frame_start ? S_LATCH : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign coord_valid = r_valid;
    assign busy        = (r_state == S_LATCH) || (r_state == S_RUN);
    assign frame_done  = (r_state == S_DONE);
    assign line_last   = r_valid && w_line_end;
    assign frame_last  = r_valid && w_frame_end;
    assign dst_x       = r_dst_x;
    assign dst_y       = r_dst_y;
    assign src_x       = w_x_clamp ? X_MAXC : w_x_int[COORD_WIDTH-1:0];
    assign src_x_frac  = w_x_clamp ? '0 : r_x_acc[FRAC_BITS-1:0];
    assign src_y       = w_y_clamp ? Y_MAXC : w_y_int[COORD_WIDTH-1:0];
    assign src_y_frac  = w_y_clamp ? '0 : r_y_acc[FRAC_BITS-1:0];
endmodule
